// File: rtl/a5_wb_regs.sv
// Wishbone classic register slave for the A5 keystream buffer (key/frame config, FIFO pop, status); IRQ under A5_WB_IRQ_EN.
// Ack one cycle after each request, never stalls; buf_load/buf_rd_en are one-cycle registered pulses in the ack cycle.
module a5_wb_regs #(
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [3:0]            wb_sel_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  buf_load,
   output logic                  buf_rd_en,
   input  logic [31:0]           buf_data,
   input  logic                  buf_empty,
   input  logic                  buf_full,
   input  logic                  buf_busy,
   output logic [63:0]           key,
   output logic [21:0]           frame,
   output logic                  irq
);

   localparam logic [2:0] A_KEY_LO = 3'd0;
   localparam logic [2:0] A_KEY_HI = 3'd1;
   localparam logic [2:0] A_FRAME  = 3'd2;
   localparam logic [2:0] A_CTRL   = 3'd3;
   localparam logic [2:0] A_DATA   = 3'd4;
   localparam logic [2:0] A_COUNT  = 3'd5;

   logic [31:0]          key_lo, key_hi;
   logic [21:0]          frame_q;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 underflow;
   logic                 ie;
   logic                 irq_q;
   logic [31:0]          rd_mux;

   logic [2:0] reg_sel;
   logic       req, wr, rd, cfg_wr, ctrl_wr;
   logic       pop_ok, pop_miss, start, clr_uf;
   logic       unused_adr;

   assign reg_sel    = wb_adr_i[4:2];
   assign unused_adr = ^wb_adr_i;

   // A request is only accepted while no ack is outstanding, giving one ack per request.
   assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
   assign wr       = req & wb_we_i;
   assign rd       = req & ~wb_we_i;
   assign cfg_wr   = wr & ~buf_busy;
   assign ctrl_wr  = wr & (reg_sel == A_CTRL) & wb_sel_i[0];
   assign start    = ctrl_wr & wb_dat_i[0];
   assign clr_uf   = ctrl_wr & wb_dat_i[1];
   assign pop_ok   = rd & (reg_sel == A_DATA) & ~buf_empty;
   assign pop_miss = rd & (reg_sel == A_DATA) & buf_empty;

   always_comb begin
      rd_mux = 32'd0;
      case (reg_sel)
         A_KEY_LO: rd_mux = key_lo;
         A_KEY_HI: rd_mux = key_hi;
         A_FRAME:  rd_mux = 32'(frame_q);
         A_CTRL:   rd_mux = {26'd0, irq_q, ie, underflow, buf_busy, buf_full, buf_empty};
         A_DATA:   rd_mux = buf_empty ? 32'd0 : buf_data;
         A_COUNT:  rd_mux = 32'(cnt);
         default:  rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_ack_o  <= 1'b0;
         wb_dat_o  <= 32'd0;
         buf_load  <= 1'b0;
         buf_rd_en <= 1'b0;
         key_lo    <= 32'd0;
         key_hi    <= 32'd0;
         frame_q   <= 22'd0;
         cnt       <= '0;
         underflow <= 1'b0;
      end else begin
         wb_ack_o  <= req;
         buf_load  <= start;
         buf_rd_en <= pop_ok;
         if (rd)
            wb_dat_o <= rd_mux;
         for (int i = 0; i < 4; i++) begin
            if (cfg_wr && reg_sel == A_KEY_LO && wb_sel_i[i])
               key_lo[8*i +: 8] <= wb_dat_i[8*i +: 8];
            if (cfg_wr && reg_sel == A_KEY_HI && wb_sel_i[i])
               key_hi[8*i +: 8] <= wb_dat_i[8*i +: 8];
         end
         if (cfg_wr && reg_sel == A_FRAME) begin
            if (wb_sel_i[0]) frame_q[7:0]   <= wb_dat_i[7:0];
            if (wb_sel_i[1]) frame_q[15:8]  <= wb_dat_i[15:8];
            if (wb_sel_i[2]) frame_q[21:16] <= wb_dat_i[21:16];
         end
         if (start)
            cnt <= '0;
         else if (pop_ok && cnt != '1)
            cnt <= cnt + CNT_WIDTH'(1);
         // A new underflow outranks a simultaneous clear.
         if (pop_miss)
            underflow <= 1'b1;
         else if (clr_uf)
            underflow <= 1'b0;
      end
   end

`ifdef A5_WB_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie    <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         if (ctrl_wr)
            ie <= wb_dat_i[2];
         irq_q <= ie & ~buf_empty;
      end
   end
`else
   assign ie    = 1'b0;
   assign irq_q = 1'b0;
`endif

   assign key   = {key_hi, key_lo};
   assign frame = frame_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_a5_wb_regs.sv
// Directed bench for a5_wb_regs: register map, byte enables, FIFO pops, underflow, status, IRQ and async reset.
module tb_a5_wb_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [4:0]  wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;
   logic        buf_load, buf_rd_en;
   logic [31:0] buf_data;
   logic        buf_empty, buf_full, buf_busy;
   logic [63:0] key;
   logic [21:0] frame;
   logic        irq;

   int n_vec = 0;
   int n_bad = 0;
   int overlap = 0;

   a5_wb_regs #(.ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .buf_load(buf_load), .buf_rd_en(buf_rd_en),
      .buf_data(buf_data), .buf_empty(buf_empty), .buf_full(buf_full), .buf_busy(buf_busy),
      .key(key), .frame(frame), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus transaction; counts rd_en/load pulses from request through the cycle after ack.
   task automatic wb_xfer(input logic we_v, input logic [4:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat,
                          output int pops, output int loads);
      bit got;
      pops = 0; loads = 0; got = 0; rdat = '0;
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we_v;
      wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
      for (int n = 0; n < 8 && !got; n++) begin
         @(posedge clk); #1;
         pops  += int'(buf_rd_en);
         loads += int'(buf_load);
         if (buf_rd_en && buf_load) overlap++;
         if (wb_ack_o) begin
            got  = 1;
            rdat = wb_dat_o;
         end
      end
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      if (!got) check("ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      pops  += int'(buf_rd_en);
      loads += int'(buf_load);
      if (buf_rd_en && buf_load) overlap++;
      check("ack_one_cycle", 64'(wb_ack_o), 64'd0);
   endtask

   logic [31:0] rdat;
   int pops, loads, acks;

   initial begin
      reset = 1'b1;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_adr_i = 0; wb_dat_i = 0;
      buf_data = 32'd0; buf_empty = 1'b1; buf_full = 1'b0; buf_busy = 1'b0;
      #12;
      check("rst_outs", 64'({wb_ack_o, buf_load, buf_rd_en, irq, wb_dat_o}), 64'd0);
      check("rst_key", key, 64'd0);
      check("rst_frame", 64'(frame), 64'd0);
      @(negedge clk); reset = 1'b0;

      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_after_rst", 64'(rdat), 64'h01);
      wb_xfer(0, 5'h14, 0, 0, rdat, pops, loads);
      check("count_after_rst", 64'(rdat), 64'd0);

      // Configuration registers and byte enables
      wb_xfer(1, 5'h00, 32'h89ABCDEF, 4'hF, rdat, pops, loads);
      wb_xfer(1, 5'h04, 32'h01234567, 4'hF, rdat, pops, loads);
      wb_xfer(1, 5'h08, 32'hFFC00134, 4'hF, rdat, pops, loads);
      check("key_full", key, 64'h0123456789ABCDEF);
      check("frame_full", 64'(frame), 64'h000134);
      wb_xfer(0, 5'h08, 0, 0, rdat, pops, loads);
      check("frame_read", 64'(rdat), 64'h00000134);
      wb_xfer(1, 5'h00, 32'h000000FF, 4'b0001, rdat, pops, loads);
      check("key_byte0", key, 64'h0123456789ABCDFF);
      wb_xfer(0, 5'h04, 0, 0, rdat, pops, loads);
      check("key_hi_read", 64'(rdat), 64'h01234567);

      buf_busy = 1'b1;
      wb_xfer(1, 5'h00, 32'h11111111, 4'hF, rdat, pops, loads);
      check("key_busy_ignored", key, 64'h0123456789ABCDFF);
      buf_busy = 1'b0;

      // Single pop
      buf_empty = 1'b0; buf_data = 32'hDEADBEEF;
      wb_xfer(0, 5'h10, 0, 0, rdat, pops, loads);
      check("data_read", 64'(rdat), 64'hDEADBEEF);
      check("data_pops", 64'(pops), 64'd1);
      wb_xfer(0, 5'h14, 0, 0, rdat, pops, loads);
      check("count_one", 64'(rdat), 64'd1);

      // START: one load pulse, counter cleared
      wb_xfer(1, 5'h0C, 32'h1, 4'h1, rdat, pops, loads);
      check("start_loads", 64'(loads), 64'd1);
      wb_xfer(0, 5'h14, 0, 0, rdat, pops, loads);
      check("count_cleared", 64'(rdat), 64'd0);

      // Four reads with strobe held: ack every other cycle
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 5'h10;
      acks = 0; pops = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         acks += int'(wb_ack_o);
         pops += int'(buf_rd_en);
      end
      wb_cyc_i = 0; wb_stb_i = 0;
      @(posedge clk); #1;
      pops += int'(buf_rd_en);
      check("b2b_acks", 64'(acks), 64'd4);
      check("b2b_pops", 64'(pops), 64'd4);
      wb_xfer(0, 5'h14, 0, 0, rdat, pops, loads);
      check("count_four", 64'(rdat), 64'd4);

      // Unused addresses and DATA write
      wb_xfer(1, 5'h10, 32'h5555AAAA, 4'hF, rdat, pops, loads);
      check("data_write_nopop", 64'(pops), 64'd0);
      wb_xfer(0, 5'h18, 0, 0, rdat, pops, loads);
      check("unused_read", 64'(rdat), 64'd0);
      wb_xfer(1, 5'h1C, 32'hFFFFFFFF, 4'hF, rdat, pops, loads);
      check("unused_write_key", key, 64'h0123456789ABCDFF);

      // Underflow
      buf_empty = 1'b1;
      wb_xfer(0, 5'h10, 0, 0, rdat, pops, loads);
      check("underflow_data", 64'(rdat), 64'd0);
      check("underflow_nopop", 64'(pops), 64'd0);
      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_underflow", 64'(rdat), 64'h09);
      wb_xfer(1, 5'h0C, 32'h2, 4'h1, rdat, pops, loads);
      check("clr_no_load", 64'(loads), 64'd0);
      buf_full = 1'b1; buf_empty = 1'b0;
      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_cleared_full", 64'(rdat), 64'h02);
      buf_full = 1'b0;

      // Interrupt
      wb_xfer(1, 5'h0C, 32'h4, 4'h1, rdat, pops, loads);
`ifdef A5_WB_IRQ_EN
      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_ie_irq", 64'(rdat), 64'h30);
      @(negedge clk); buf_empty = 1'b1;
      @(posedge clk); #1;
      check("irq_drained", 64'(irq), 64'd0);
      @(negedge clk); buf_empty = 1'b0; #1;
      check("irq_registered", 64'(irq), 64'd0);
      @(posedge clk); #1;
      check("irq_set", 64'(irq), 64'd1);
      @(negedge clk); buf_empty = 1'b1;
      @(posedge clk); #1;
      check("irq_clear", 64'(irq), 64'd0);
`else
      repeat (2) @(posedge clk);
      #1;
      check("irq_tied_low", 64'(irq), 64'd0);
      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_no_ie", 64'(rdat), 64'h00);
`endif

      // Set underflow, then reset in the middle of an ack cycle
      buf_empty = 1'b1;
      wb_xfer(0, 5'h10, 0, 0, rdat, pops, loads);
      @(negedge clk);
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 5'h00;
      @(posedge clk); #1;
      check("pre_rst_ack", 64'(wb_ack_o), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ack", 64'(wb_ack_o), 64'd0);
      check("async_rst_dat", 64'(wb_dat_o), 64'd0);
      check("async_rst_key", key, 64'd0);
      check("async_rst_frame", 64'(frame), 64'd0);
      wb_cyc_i = 0; wb_stb_i = 0;
      @(negedge clk); reset = 1'b0; buf_busy = 1'b1; buf_empty = 1'b1;
      wb_xfer(0, 5'h0C, 0, 0, rdat, pops, loads);
      check("status_post_rst", 64'(rdat), 64'h05);
      buf_busy = 1'b0;

      check("pop_load_overlap", 64'(overlap), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
